// File: rtl/rng_health_monitor.sv
// Continuous health tests (repetition count + adaptive proportion) on an
// 8-bit RNG stream, with sticky alarms, event count and a healthy qualifier.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   sample_valid      : accept sample this cycle
//   sample[7:0]       : random byte
//   alarm_clr         : clear alarms and restart both tests
//   rct_fail          : sticky repetition-count alarm
//   apt_fail          : sticky adaptive-proportion alarm
//   healthy           : a full window has completed with no alarm set
//   window_done       : one-cycle pulse per completed APT window
//   fail_events[7:0]  : saturating count of alarm assertions
module rng_health_monitor #(
  parameter int unsigned RCT_CUTOFF = 8,
  parameter int unsigned APT_WINDOW = 64,
  parameter int unsigned APT_CUTOFF = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       alarm_clr,
  output logic       rct_fail,
  output logic       apt_fail,
  output logic       healthy,
  output logic       window_done,
  output logic [7:0] fail_events
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW + 1);

  localparam logic [RW-1:0] RCT_MAX = RW'(RCT_CUTOFF);
  localparam logic [WW-1:0] WIN_MAX = WW'(APT_WINDOW);
  localparam logic [WW-1:0] APT_MAX = WW'(APT_CUTOFF);

  typedef enum logic [1:0] {
    WARMUP,
    OK,
    FAILED
  } hstate_e;

  hstate_e       state_q;
  logic          have_last_q;
  logic [7:0]    last_q;
  logic [7:0]    last_d;
  logic [RW-1:0] rep_cnt_q;
  logic [RW-1:0] rep_cnt_d;
  logic [7:0]    apt_ref_q;
  logic [7:0]    apt_ref_d;
  logic [WW-1:0] apt_cnt_q;
  logic [WW-1:0] apt_cnt_d;
  logic [WW-1:0] win_cnt_q;
  logic [WW-1:0] win_cnt_d;
  logic [WW-1:0] win_inc;
  logic          rct_fail_q;
  logic          apt_fail_q;
  logic          healthy_q;
  logic          window_done_q;
  logic          window_done_d;
  logic [7:0]    fail_events_q;
  logic [7:0]    fail_events_d;
  logic [8:0]    fe_sum;
  logic          same;
  logic          win_first;
  logic          apt_hit;
  logic          rct_set;
  logic          apt_set;
  logic          rct_rise;
  logic          apt_rise;

  // Next state assuming the current sample is accepted.
  always_comb begin
    same      = have_last_q && (sample == last_q);
    last_d    = same ? last_q : sample;
    rep_cnt_d = RW'(1);
    if (same) begin
      rep_cnt_d = (rep_cnt_q == RCT_MAX) ? rep_cnt_q
                                         : rep_cnt_q + RW'(1);
    end

    // Empty window: this sample becomes the reference.
    win_first = (win_cnt_q == '0);
    apt_ref_d = win_first ? sample : apt_ref_q;
    apt_hit   = !win_first && (sample == apt_ref_q);
    apt_cnt_d = apt_cnt_q;
    if (win_first) begin
      apt_cnt_d = WW'(1);
    end else if (apt_hit && apt_cnt_q != WIN_MAX) begin
      apt_cnt_d = apt_cnt_q + WW'(1);
    end

    win_inc       = win_cnt_q + WW'(1);
    window_done_d = (win_inc == WIN_MAX);
    win_cnt_d     = window_done_d ? '0 : win_inc;

    rct_set  = (rep_cnt_d == RCT_MAX);
    apt_set  = (apt_cnt_d == APT_MAX);
    // Only a 0->1 flag transition counts as a new event.
    rct_rise = rct_set && !rct_fail_q;
    apt_rise = apt_set && !apt_fail_q;

    fe_sum = {1'b0, fail_events_q}
           + 9'(rct_rise) + 9'(apt_rise);
    fail_events_d = fe_sum[8] ? 8'hFF : fe_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WARMUP;
      have_last_q   <= 1'b0;
      last_q        <= '0;
      rep_cnt_q     <= '0;
      apt_ref_q     <= '0;
      apt_cnt_q     <= '0;
      win_cnt_q     <= '0;
      rct_fail_q    <= 1'b0;
      apt_fail_q    <= 1'b0;
      healthy_q     <= 1'b0;
      window_done_q <= 1'b0;
      fail_events_q <= '0;
    end else if (alarm_clr) begin
      // Sample presented alongside the clear is dropped.
      state_q       <= WARMUP;
      have_last_q   <= 1'b0;
      rep_cnt_q     <= '0;
      apt_cnt_q     <= '0;
      win_cnt_q     <= '0;
      rct_fail_q    <= 1'b0;
      apt_fail_q    <= 1'b0;
      healthy_q     <= 1'b0;
      window_done_q <= 1'b0;
    end else if (sample_valid) begin
      have_last_q   <= 1'b1;
      last_q        <= last_d;
      rep_cnt_q     <= rep_cnt_d;
      apt_ref_q     <= apt_ref_d;
      apt_cnt_q     <= apt_cnt_d;
      win_cnt_q     <= win_cnt_d;
      rct_fail_q    <= rct_fail_q | rct_set;
      apt_fail_q    <= apt_fail_q | apt_set;
      window_done_q <= window_done_d;
      fail_events_q <= fail_events_d;
      case (state_q)
        WARMUP, OK: begin
          if (rct_set || apt_set) begin
            state_q   <= FAILED;
            healthy_q <= 1'b0;
          end else if (state_q == WARMUP
                       && window_done_d) begin
            state_q   <= OK;
            healthy_q <= 1'b1;
          end
        end
        FAILED: begin
          state_q   <= FAILED;
          healthy_q <= 1'b0;
        end
        default: begin
          state_q   <= WARMUP;
          healthy_q <= 1'b0;
        end
      endcase
    end else begin
      window_done_q <= 1'b0;
    end
  end

  assign rct_fail    = rct_fail_q;
  assign apt_fail    = apt_fail_q;
  assign healthy     = healthy_q;
  assign window_done = window_done_q;
  assign fail_events = fail_events_q;

endmodule
